// File: rtl/wb_dest_decoder.sv
// wb_dest_decoder: write-back destination decoder for the register file.
// Takes a 5-bit destination register number plus write data and presents a
// registered one-hot 32-bit write enable with aligned data. It also flags
// read-address hazards against the pending write.
//
// Optional feature macro: ZERO_REG_SUPPRESS_EN
//   When defined, register 31 is the hard-zero register. we[31] and the
//   hazard hits for address 31 are forced low. The write still occupies the
//   stage, still retires, and still counts in wr_count.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready.
// in_ready = !out_valid || !stall, so a stalled full stage refuses new work.
// The output side has no ready signal. A held write retires on any edge where
// out_valid && !stall. A retire and an accept may share one edge.
module wb_dest_decoder #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  stall,
    output logic [31:0]           we,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  out_valid,
    input  logic [4:0]            rd_addr_a,
    input  logic [4:0]            rd_addr_b,
    output logic                  hit_a,
    output logic                  hit_b,
    output logic [15:0]           wr_count
);

    // The only state is the occupancy of the single output register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [4:0]  addr_q;
    logic        accept;
    logic        retire;
    logic        zero_reg;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || !stall;
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && !stall;

`ifdef ZERO_REG_SUPPRESS_EN
    assign zero_reg = (addr_q == 5'd31);
`else
    assign zero_reg = 1'b0;
`endif

    // Next-state logic for the occupancy bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (retire && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // State register. Reset drops any pending write immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Capture the destination and data on every accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wr_data <= '0;
        end else if (accept) begin
            addr_q  <= in_addr;
            wr_data <= in_data;
        end
    end

    // Count retired writes, wrapping at 2^16.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       wr_count <= '0;
        else if (retire) wr_count <= wr_count + 16'd1;
    end

    // One-hot decode of the held destination, gated by occupancy.
    always_comb begin
        we = '0;
        if (out_valid && !zero_reg) we[addr_q] = 1'b1;
    end

    // Hazard compare of the pending write against both read ports.
    always_comb begin
        hit_a = out_valid && !zero_reg && (addr_q == rd_addr_a);
        hit_b = out_valid && !zero_reg && (addr_q == rd_addr_b);
    end

endmodule

// File: tb/tb_wb_dest_decoder.sv
// Testbench for wb_dest_decoder: directed scenarios plus randomized traffic,
// with a queue-based scoreboard and a negedge monitor.
module tb_wb_dest_decoder;

    localparam int DW = 64;
    localparam int W  = 5 + DW;

`ifdef ZERO_REG_SUPPRESS_EN
    localparam bit SUPPRESS = 1'b1;
`else
    localparam bit SUPPRESS = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_addr;
    logic [DW-1:0] in_data;
    logic          stall;
    logic [31:0]   we;
    logic [DW-1:0] wr_data;
    logic          out_valid;
    logic [4:0]    rd_addr_a;
    logic [4:0]    rd_addr_b;
    logic          hit_a;
    logic          hit_b;
    logic [15:0]   wr_count;

    int checks = 0;
    int errors = 0;

    // Scoreboard: writes accepted but not yet retired, oldest first.
    logic [W-1:0] exp_q[$];
    logic         m_pending;
    logic [15:0]  m_count;

    wb_dest_decoder #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .stall(stall), .we(we),
        .wr_data(wr_data), .out_valid(out_valid), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .hit_a(hit_a), .hit_b(hit_b), .wr_count(wr_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_we(input logic [4:0] a);
        if (SUPPRESS && a == 5'd31) return 32'h0;
        return 32'h1 << a;
    endfunction

    // Reference model: at each edge a stalled full stage refuses new work,
    // otherwise a valid request is taken; a full unstalled stage retires.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_pending = 1'b0;
            m_count   = 16'd0;
        end else begin
            logic take, done;
            done = m_pending && !stall;
            take = in_valid && (!m_pending || !stall);
            if (done) m_count = m_count + 16'd1;
            if (take) begin
                exp_q.push_back({in_addr, in_data});
                m_pending = 1'b1;
            end else if (done) begin
                m_pending = 1'b0;
            end
        end
    end

    // Monitor: compare presented outputs with the oldest expected write,
    // popping it when the stage retires on the coming edge.
    always @(negedge clk) begin
        logic         pend;
        logic [W-1:0] e;
        logic [4:0]   a;
        logic         ha, hb;
        pend = (exp_q.size() != 0);
        check("out_valid", out_valid, pend);
        check("in_ready", in_ready, !pend || !stall);
        check("wr_count", wr_count, m_count);
        if (pend) begin
            e  = exp_q[0];
            a  = e[W-1:DW];
            ha = !(SUPPRESS && a == 5'd31) && (a == rd_addr_a);
            hb = !(SUPPRESS && a == 5'd31) && (a == rd_addr_b);
            check("we", we, exp_we(a));
            check("wr_data", wr_data, e[DW-1:0]);
            check("hit_a", hit_a, ha);
            check("hit_b", hit_b, hb);
            if (!stall) void'(exp_q.pop_front());
        end else begin
            check("we_idle", we, 64'h0);
            check("hit_a_idle", hit_a, 1'b0);
            check("hit_b_idle", hit_b, 1'b0);
        end
    end

    // Driver: set inputs, advance one edge, land 1 time unit after it.
    task automatic cycle(input logic v, input logic [4:0] a, input logic [DW-1:0] d, input logic s);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        stall    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, '0, 1'b0);
    endtask

    initial begin
        logic [4:0] last_addr;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        stall     = 1'b0;
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_wr_count", wr_count, 16'd0);
        reset = 1'b0;

        // Single write to register 5
        cycle(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0);
        check("t1_we", we, 32'h0000_0020);
        check("t1_wr_data", wr_data, 64'hDEAD_BEEF);
        check("t1_out_valid", out_valid, 1'b1);
        idle(1);
        check("t1_drain", out_valid, 1'b0);
        check("t1_count", wr_count, 16'd1);

        // Back-to-back writes to 0, 1, 2
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'(i), 64'(100 + i), 1'b0);
            check("t2_we", we, 32'h1 << i);
            check("t2_in_ready", in_ready, 1'b1);
        end
        idle(1);
        check("t2_count", wr_count, 16'd4);

        // Stall holds register 7 while register 9 waits
        cycle(1'b1, 5'd7, 64'h7777, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'd9, 64'h9999, 1'b1);
            check("t3_hold_we", we, 32'h80);
            check("t3_in_ready", in_ready, 1'b0);
        end
        cycle(1'b1, 5'd9, 64'h9999, 1'b0);
        check("t3_we9", we, 32'h200);
        idle(1);
        check("t3_count", wr_count, 16'd6);

        // Hazard compare
        rd_addr_a = 5'd12;
        rd_addr_b = 5'd13;
        cycle(1'b1, 5'd12, 64'h1212, 1'b0);
        check("t4_hit_a", hit_a, 1'b1);
        check("t4_hit_b", hit_b, 1'b0);
        idle(1);
        check("t4_hit_a_off", hit_a, 1'b0);
        check("t4_hit_b_off", hit_b, 1'b0);

        // Register 31
        rd_addr_a = 5'd31;
        cycle(1'b1, 5'd31, 64'h3131, 1'b0);
        check("t5_we31", we, SUPPRESS ? 32'h0 : 32'h8000_0000);
        check("t5_hit31", hit_a, !SUPPRESS);
        idle(1);
        check("t5_count", wr_count, 16'd8);

        // Asynchronous reset while a stalled write is held
        cycle(1'b1, 5'd3, 64'h3333, 1'b0);
        cycle(1'b0, 5'd0, '0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_we", we, 32'h0);
        check("t6_wr_data", wr_data, 64'h0);
        check("t6_wr_count", wr_count, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 1'b0;

        // Randomized traffic
        last_addr = 5'd0;
        for (int i = 0; i < 600; i++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            rd_addr_a = ($urandom_range(0, 1) == 0) ? last_addr : 5'($urandom_range(0, 31));
            rd_addr_b = ($urandom_range(0, 2) == 0) ? last_addr : 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 9) < 7, a, {$urandom, $urandom}, $urandom_range(0, 9) < 3);
            if (in_valid) last_addr = a;
        end
        idle(3);
        check("end_out_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
